trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap and privilege sequencer that consumes the decoder's exception, return and wait-for-interrupt requests. It is the handling end of the decode-side RaiseExcep/ExcepCode/Ret/RetFrom/Wfi signalling. Sits beside the execute stage, owns the machine trap CSRs (mstatus, mtvec, mepc, mcause) and the current privilege mode, and drives the PC redirect, pipeline flush and stall.

## Interface
- XLEN, 32: data/PC width.
- RESET_MTVEC, 32'h0000_0100: mtvec reset value.

Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid  in  1  instruction in the stage is live; requests are ignored when 0.
- pc  in  XLEN  PC of that instruction.
- raise_excep  in  1  synchronous exception request.
- excep_code  in  4  exception cause.
- ret  in  1  xRET request.
- ret_from  in  2  privilege being returned from (USER=0, SUPERV=1, MACHINE=3).
- wfi  in  1  WFI request.
- irq_ext, irq_timer  in  1  level interrupt lines.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  CSR write data.
- csr_rdata  out  XLEN  combinational read of csr_addr; 0 for unmapped addresses.
- mode  out  2  current privilege.
- redirect  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- flush  out  1  squash younger instructions; equals redirect.
- stall  out  1  hold the front end.

## Operation
- CSRs:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, bits12:11 MPP, all other bits read 0.
  - mtvec 0x305, direct mode only; bits1:0 are forced to 0.
  - mepc 0x341; bits1:0 read 0.
  - mcause 0x342.
- FSM states: RUN, WFI_WAIT.
- Request priority in RUN with valid=1: interrupt > raise_excep > ret > wfi.
- Interrupt taken when (irq_ext|irq_timer) and (MIE=1 or mode≠MACHINE).
  - Cause: irq_ext gives mcause=32'h8000_000B; else irq_timer gives 32'h8000_0007.
  - mepc=pc; the instruction does not retire.
- Trap entry (interrupt or exception):
  - Exception cause: mcause={28'b0,excep_code}.
  - mepc=pc.
  - MPP=mode, MPIE=MIE, MIE=0, mode=MACHINE.
  - redirect_pc=mtvec.
  - All traps go to machine mode; there is no delegation.
- ret with ret_from=MACHINE: mode=MPP, MIE=MPIE, MPIE=1, MPP=USER, redirect_pc=mepc.
- ret with ret_from≠MACHINE: treated as an exception with code 2.
- wfi: enter WFI_WAIT and store wakeup PC pc+4; stall=1 while in WFI_WAIT.
- WFI_WAIT exit: any irq line high, regardless of MIE.
  - If the interrupt is enabled, take the trap with mepc=pc+4.
  - Otherwise return to RUN with no redirect.
- CSR write and trap/ret in the same cycle: the trap/ret update of the affected fields wins; writes to other CSRs still apply.

## Timing
- Requests are sampled at edge N. redirect, flush, new mode and CSR values are visible after edge N (cycle N+1), all registered.
- redirect is high for exactly one cycle; no back-to-back redirects, since requests in the redirect cycle are ignored.
- stall rises in cycle N+1 after a sampled wfi. It falls in the cycle after the wake edge; on an enabled wake, redirect pulses in that same cycle.
- csr_rdata reflects writes from the following cycle.
- Reset values: mode=MACHINE, mtvec=RESET_MTVEC, mstatus=0, mepc=0, mcause=0, redirect=0, flush=0, stall=0, FSM=RUN, redirect_pc=0.
- Reset mid-WFI returns to RUN immediately with stall=0.
- pc+4 wraps modulo 2^XLEN.

## Configuration
- TRAP_IRQ_EN defined: interrupt handling and WFI_WAIT are as above.
- TRAP_IRQ_EN undefined:
  - irq_ext and irq_timer are ignored.
  - wfi retires as a NOP: no stall, no state change.
  - The WFI_WAIT state is not built.

## Test plan
- Exception entry: mode=USER, MIE=1, valid, raise_excep, excep_code=8, pc=0x2000. Required next cycle: redirect=1, redirect_pc=0x100, mepc=0x2000, mcause=8, mode=3, MPP=0, MPIE=1, MIE=0.
- mret: from the state above, ret with ret_from=3. Required: redirect_pc=0x2000, mode=0, MIE=1, MPP=0.
- Interrupt priority: MIE=1, irq_ext and irq_timer both high, raise_excep=1, pc=0x40. Required: mcause=0x8000000B, mepc=0x40.
- WFI wake: wfi at pc=0x80 with MIE=0; hold the irq lines low for 5 cycles, then raise irq_timer.
  - Required: stall=1 for those cycles; on wake, stall=0 with no redirect.
  - Repeat with MIE=1: required mepc=0x84, mcause=0x80000007.
- CSR collision: csr_we to mepc with 0x1234 in the same cycle as an exception at pc=0x300. Required: mepc=0x300. A mtvec write of 0x503 reads back 0x500.
- Reset mid-WFI: assert rst while stall=1. Required: stall=0 and mode=3 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap/xRET/WFI sequencer owning mstatus, mtvec, mepc, mcause and the privilege mode.
// Define TRAP_IRQ_EN to build interrupt handling and the WFI_WAIT state; otherwise WFI retires as a NOP.
module trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic            raise_excep,
  input  logic [3:0]      excep_code,
  input  logic            ret,
  input  logic [1:0]      ret_from,
  input  logic            wfi,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic [1:0]      mode,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            stall
);

  localparam logic [1:0]      M_MODE       = 2'b11;
  localparam logic [1:0]      U_MODE       = 2'b00;
  localparam logic [11:0]     ADDR_NONE    = 12'h000;
  localparam logic [11:0]     ADDR_MSTATUS = 12'h300;
  localparam logic [11:0]     ADDR_MTVEC   = 12'h305;
  localparam logic [11:0]     ADDR_MEPC    = 12'h341;
  localparam logic [11:0]     ADDR_MCAUSE  = 12'h342;
  localparam logic [XLEN-1:0] ALIGN_MASK   = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] CAUSE_EXT    = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_TMR    = {1'b1, {(XLEN-5){1'b0}}, 4'h7};
  localparam logic [XLEN-1:0] CAUSE_ILLRET = {{(XLEN-4){1'b0}}, 4'd2};

  logic [1:0]      mode_q, mode_d;
  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [1:0]      mpp_q, mpp_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic            redirect_q, redirect_d, stall_q, stall_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            trap_s, mret_s, irq_en_s;
  logic [XLEN-1:0] trap_cause_s, trap_epc_s, irq_cause_s, mstatus_s;
  logic [11:0]     wr_addr_s;

  assign irq_cause_s = irq_ext ? CAUSE_EXT : CAUSE_TMR;
  assign wr_addr_s   = csr_we ? csr_addr : ADDR_NONE;

`ifdef TRAP_IRQ_EN
  typedef enum logic [0:0] {RUN = 1'b0, WFI_WAIT = 1'b1} state_e;
  state_e          state_q, state_d;
  logic [XLEN-1:0] wake_pc_q, wake_pc_d;
  logic            irq_pend_s;

  assign irq_pend_s = irq_ext | irq_timer;
  assign irq_en_s   = irq_pend_s & (mie_q | (mode_q != M_MODE));
`else
  assign irq_en_s = 1'b0;
`endif

  // Next-state: CSR writes first, then trap/return field updates override them.
  always_comb begin
    mode_d        = mode_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mpp_d         = mpp_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    trap_s        = 1'b0;
    mret_s        = 1'b0;
    trap_cause_s  = {XLEN{1'b0}};
    trap_epc_s    = pc;
`ifdef TRAP_IRQ_EN
    state_d       = state_q;
    wake_pc_d     = wake_pc_q;
`endif

    case (wr_addr_s)
      ADDR_MSTATUS: begin
        mie_d  = csr_wdata[3];
        mpie_d = csr_wdata[7];
        mpp_d  = csr_wdata[12:11];
      end
      ADDR_MTVEC:  mtvec_d  = csr_wdata & ALIGN_MASK;
      ADDR_MEPC:   mepc_d   = csr_wdata & ALIGN_MASK;
      ADDR_MCAUSE: mcause_d = csr_wdata;
      default:     mcause_d = mcause_d;
    endcase

`ifdef TRAP_IRQ_EN
    if (state_q == WFI_WAIT) begin
      if (irq_pend_s) begin
        state_d      = RUN;
        trap_s       = irq_en_s;
        trap_cause_s = irq_cause_s;
        trap_epc_s   = wake_pc_q;
      end else begin
        state_d = WFI_WAIT;
      end
    end else
`endif
    // The redirect cycle's instruction is being squashed, so its requests are dropped.
    if (valid && !redirect_q) begin
      if (irq_en_s) begin
        trap_s       = 1'b1;
        trap_cause_s = irq_cause_s;
      end else if (raise_excep) begin
        trap_s       = 1'b1;
        trap_cause_s = {{(XLEN-4){1'b0}}, excep_code};
      end else if (ret) begin
        if (ret_from == M_MODE) begin
          mret_s = 1'b1;
        end else begin
          trap_s       = 1'b1;
          trap_cause_s = CAUSE_ILLRET;
        end
      end else if (wfi) begin
`ifdef TRAP_IRQ_EN
        state_d   = WFI_WAIT;
        wake_pc_d = pc + {{(XLEN-3){1'b0}}, 3'd4};
`else
        trap_s    = 1'b0;
`endif
      end else begin
        trap_s = 1'b0;
      end
    end else begin
      trap_s = 1'b0;
    end

    if (trap_s) begin
      mepc_d        = trap_epc_s & ALIGN_MASK;
      mcause_d      = trap_cause_s;
      mpp_d         = mode_q;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      mode_d        = M_MODE;
      redirect_d    = 1'b1;
      redirect_pc_d = mtvec_q;
    end else if (mret_s) begin
      mode_d        = mpp_q;
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      mpp_d         = U_MODE;
      redirect_d    = 1'b1;
      redirect_pc_d = mepc_q;
    end else begin
      redirect_d = 1'b0;
    end

`ifdef TRAP_IRQ_EN
    stall_d = (state_d == WFI_WAIT);
`else
    stall_d = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= M_MODE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mpp_q         <= 2'b00;
      mtvec_q       <= RESET_MTVEC & ALIGN_MASK;
      mepc_q        <= {XLEN{1'b0}};
      mcause_q      <= {XLEN{1'b0}};
      redirect_q    <= 1'b0;
      redirect_pc_q <= {XLEN{1'b0}};
      stall_q       <= 1'b0;
`ifdef TRAP_IRQ_EN
      state_q       <= RUN;
      wake_pc_q     <= {XLEN{1'b0}};
`endif
    end else begin
      mode_q        <= mode_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mpp_q         <= mpp_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      stall_q       <= stall_d;
`ifdef TRAP_IRQ_EN
      state_q       <= state_d;
      wake_pc_q     <= wake_pc_d;
`endif
    end
  end

  // Combinational CSR read port.
  always_comb begin
    mstatus_s        = {XLEN{1'b0}};
    mstatus_s[3]     = mie_q;
    mstatus_s[7]     = mpie_q;
    mstatus_s[12:11] = mpp_q;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = mstatus_s;
      ADDR_MTVEC:   csr_rdata = mtvec_q;
      ADDR_MEPC:    csr_rdata = mepc_q;
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      default:      csr_rdata = {XLEN{1'b0}};
    endcase
  end

  assign mode        = mode_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = redirect_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed scoreboard bench for trap_ctrl; interrupt/WFI steps follow TRAP_IRQ_EN like the design.
`timescale 1ns/1ps
module tb_trap_ctrl;

  localparam int K_RED = 0, K_RPC = 1, K_MODE = 2, K_STALL = 3, K_FLUSH = 4, K_CSR = 5;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MTVEC = 12'h305, A_MEPC = 12'h341, A_MCAUSE = 12'h342;

  logic        clk = 1'b0, rst = 1'b0;
  logic        valid, raise_excep, ret, wfi, irq_ext, irq_timer, csr_we;
  logic [31:0] pc, csr_wdata, csr_rdata, redirect_pc;
  logic [3:0]  excep_code;
  logic [1:0]  ret_from, mode;
  logic [11:0] csr_addr;
  logic        redirect, flush, stall;

  typedef struct {
    string       tag;
    int          kind;
    logic [11:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .valid(valid), .pc(pc), .raise_excep(raise_excep),
    .excep_code(excep_code), .ret(ret), .ret_from(ret_from), .wfi(wfi),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .mode(mode), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .stall(stall)
  );

  always #50 clk = ~clk;

  task automatic push(input string tag, input int kind, input logic [11:0] addr, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.addr = addr; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic exp_sig(input string tag, input int kind, input logic [31:0] exp);
    push(tag, kind, 12'h000, exp);
  endtask

  task automatic exp_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    push(tag, K_CSR, addr, exp);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RED:   obs = {31'd0, redirect};
        K_RPC:   obs = redirect_pc;
        K_MODE:  obs = {30'd0, mode};
        K_STALL: obs = {31'd0, stall};
        K_FLUSH: obs = {31'd0, flush};
        default: begin
          csr_addr = e.addr;
          #1;
          obs = csr_rdata;
        end
      endcase
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
    csr_addr = 12'h000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle();
    valid = 1'b0; raise_excep = 1'b0; ret = 1'b0; wfi = 1'b0; csr_we = 1'b0;
    excep_code = 4'd0; ret_from = 2'd0; pc = 32'h0; csr_wdata = 32'h0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
  endtask

  initial begin
    idle();
    irq_ext = 1'b0; irq_timer = 1'b0; csr_addr = 12'h000;
    #1 rst = 1'b1;
    #5;
    exp_sig("rst_mode", K_MODE, 32'd3);   exp_sig("rst_redirect", K_RED, 32'd0);
    exp_sig("rst_flush", K_FLUSH, 32'd0); exp_sig("rst_stall", K_STALL, 32'd0);
    exp_sig("rst_rpc", K_RPC, 32'h0);     exp_csr("rst_mtvec", A_MTVEC, 32'h100);
    exp_csr("rst_mstatus", A_MSTATUS, 32'h0); exp_csr("rst_mepc", A_MEPC, 32'h0);
    exp_csr("rst_mcause", A_MCAUSE, 32'h0);
    drain();
    @(negedge clk) rst = 1'b0;

    // Drop to user mode with MIE=1 via MPIE=1, MPP=0 and mret.
    csr_write(A_MSTATUS, 32'h80); exp_csr("setup_mstatus", A_MSTATUS, 32'h80); tick(); idle();
    valid = 1'b1; ret = 1'b1; ret_from = 2'd3; pc = 32'h10;
    exp_sig("setup_red", K_RED, 32'd1); exp_sig("setup_mode", K_MODE, 32'd0);
    exp_csr("setup_mstatus2", A_MSTATUS, 32'h88); tick(); idle();
    valid = 1'b1; raise_excep = 1'b1; excep_code = 4'd8; pc = 32'h10;
    exp_sig("redircyc_red", K_RED, 32'd0); exp_sig("redircyc_mode", K_MODE, 32'd0);
    exp_csr("redircyc_mcause", A_MCAUSE, 32'h0); tick(); idle();

    valid = 1'b1; raise_excep = 1'b1; excep_code = 4'd8; pc = 32'h2000;
    exp_sig("exc_red", K_RED, 32'd1); exp_sig("exc_flush", K_FLUSH, 32'd1);
    exp_sig("exc_rpc", K_RPC, 32'h100); exp_sig("exc_mode", K_MODE, 32'd3);
    exp_csr("exc_mepc", A_MEPC, 32'h2000); exp_csr("exc_mcause", A_MCAUSE, 32'd8);
    exp_csr("exc_mstatus", A_MSTATUS, 32'h80); tick(); idle();
    exp_sig("exc_pulse_end", K_RED, 32'd0); tick();

    valid = 1'b1; ret = 1'b1; ret_from = 2'd3; pc = 32'h2100;
    exp_sig("mret_red", K_RED, 32'd1); exp_sig("mret_rpc", K_RPC, 32'h2000);
    exp_sig("mret_mode", K_MODE, 32'd0); exp_csr("mret_mstatus", A_MSTATUS, 32'h88);
    tick(); idle(); tick();

    valid = 1'b1; ret = 1'b1; ret_from = 2'd1; pc = 32'h2004;
    exp_sig("illret_rpc", K_RPC, 32'h100); exp_sig("illret_mode", K_MODE, 32'd3);
    exp_csr("illret_mcause", A_MCAUSE, 32'd2); exp_csr("illret_mepc", A_MEPC, 32'h2004);
    exp_csr("illret_mstatus", A_MSTATUS, 32'h80); tick(); idle(); tick();

    csr_write(A_MEPC, 32'h1234); valid = 1'b1; raise_excep = 1'b1; excep_code = 4'd3; pc = 32'h300;
    exp_csr("coll_mepc", A_MEPC, 32'h300); exp_csr("coll_mcause", A_MCAUSE, 32'd3);
    exp_csr("coll_mstatus", A_MSTATUS, 32'h1800); tick(); idle(); tick();

    csr_write(A_MTVEC, 32'h503); valid = 1'b1; raise_excep = 1'b1; excep_code = 4'd5; pc = 32'h400;
    exp_sig("mtvecw_rpc", K_RPC, 32'h100); exp_csr("mtvecw_mtvec", A_MTVEC, 32'h500);
    exp_csr("mtvecw_mcause", A_MCAUSE, 32'd5); exp_csr("mtvecw_mepc", A_MEPC, 32'h400);
    tick(); idle(); tick();

    csr_write(A_MEPC, 32'h1237); exp_csr("mepc_align", A_MEPC, 32'h1234); tick(); idle();
    csr_write(A_MSTATUS, 32'hFFFF_FFFF); exp_csr("mstatus_mask", A_MSTATUS, 32'h1888); tick(); idle();
    csr_write(A_MCAUSE, 32'hDEAD_BEEF); exp_csr("mcause_wr", A_MCAUSE, 32'hDEAD_BEEF); tick(); idle();
    exp_csr("unmapped_rd", 12'h7C0, 32'h0); drain();
    raise_excep = 1'b1; excep_code = 4'd4; pc = 32'h500;
    exp_sig("novalid_red", K_RED, 32'd0); exp_csr("novalid_mcause", A_MCAUSE, 32'hDEAD_BEEF);
    tick(); idle();

`ifdef TRAP_IRQ_EN
    valid = 1'b1; raise_excep = 1'b1; excep_code = 4'd8; pc = 32'h40; irq_ext = 1'b1; irq_timer = 1'b1;
    exp_sig("irqpri_red", K_RED, 32'd1); exp_sig("irqpri_rpc", K_RPC, 32'h500);
    exp_csr("irqpri_mcause", A_MCAUSE, 32'h8000_000B); exp_csr("irqpri_mepc", A_MEPC, 32'h40);
    exp_csr("irqpri_mstatus", A_MSTATUS, 32'h1880); tick(); idle();
    irq_ext = 1'b0; irq_timer = 1'b0; tick();

    valid = 1'b1; pc = 32'h44; irq_timer = 1'b1;
    exp_sig("irqmask_red", K_RED, 32'd0); exp_csr("irqmask_mcause", A_MCAUSE, 32'h8000_000B);
    tick(); idle(); irq_timer = 1'b0;

    valid = 1'b1; wfi = 1'b1; pc = 32'h80;
    exp_sig("wfi0_stall", K_STALL, 32'd1); exp_sig("wfi0_red", K_RED, 32'd0); tick(); idle();
    for (int i = 0; i < 5; i++) begin
      exp_sig("wfi0_hold", K_STALL, 32'd1); tick();
    end
    irq_timer = 1'b1;
    exp_sig("wfi0_wake_stall", K_STALL, 32'd0); exp_sig("wfi0_wake_red", K_RED, 32'd0);
    exp_csr("wfi0_mepc", A_MEPC, 32'h40); tick(); irq_timer = 1'b0;

    csr_write(A_MSTATUS, 32'h8); exp_csr("wfi1_mie", A_MSTATUS, 32'h8); tick(); idle();
    valid = 1'b1; wfi = 1'b1; pc = 32'h80; exp_sig("wfi1_stall", K_STALL, 32'd1); tick(); idle();
    exp_sig("wfi1_hold", K_STALL, 32'd1); tick();
    irq_timer = 1'b1;
    exp_sig("wfi1_wake_stall", K_STALL, 32'd0); exp_sig("wfi1_wake_red", K_RED, 32'd1);
    exp_sig("wfi1_rpc", K_RPC, 32'h500); exp_csr("wfi1_mepc", A_MEPC, 32'h84);
    exp_csr("wfi1_mcause", A_MCAUSE, 32'h8000_0007); exp_csr("wfi1_mstatus", A_MSTATUS, 32'h1880);
    tick(); irq_timer = 1'b0; tick();

    csr_write(A_MSTATUS, 32'h8); tick(); idle();
    valid = 1'b1; wfi = 1'b1; pc = 32'hFFFF_FFFC; exp_sig("wrap_stall", K_STALL, 32'd1); tick(); idle();
    irq_ext = 1'b1;
    exp_sig("wrap_red", K_RED, 32'd1); exp_csr("wrap_mepc", A_MEPC, 32'h0);
    exp_csr("wrap_mcause", A_MCAUSE, 32'h8000_000B); tick(); irq_ext = 1'b0; tick();

    csr_write(A_MSTATUS, 32'h0); tick(); idle();
    valid = 1'b1; ret = 1'b1; ret_from = 2'd3; pc = 32'h50;
    exp_sig("user_mode", K_MODE, 32'd0); exp_csr("user_mstatus", A_MSTATUS, 32'h80); tick(); idle(); tick();
    valid = 1'b1; pc = 32'h60; irq_ext = 1'b1;
    exp_sig("uirq_red", K_RED, 32'd1); exp_sig("uirq_mode", K_MODE, 32'd3);
    exp_csr("uirq_mepc", A_MEPC, 32'h60); exp_csr("uirq_mstatus", A_MSTATUS, 32'h0);
    tick(); idle(); irq_ext = 1'b0; tick();

    valid = 1'b1; ret = 1'b1; ret_from = 2'd3; pc = 32'h64;
    exp_sig("rstw_mode0", K_MODE, 32'd0); tick(); idle(); tick();
    valid = 1'b1; wfi = 1'b1; pc = 32'h90; exp_sig("rstw_stall", K_STALL, 32'd1); tick(); idle();
    rst = 1'b1;
    #1;
    exp_sig("rstw_stall0", K_STALL, 32'd0); exp_sig("rstw_mode", K_MODE, 32'd3);
    exp_sig("rstw_rpc", K_RPC, 32'h0); exp_csr("rstw_mtvec", A_MTVEC, 32'h100);
    drain();
    @(negedge clk) rst = 1'b0;
`else
    valid = 1'b1; wfi = 1'b1; pc = 32'h80;
    exp_sig("nop_wfi_stall", K_STALL, 32'd0); exp_sig("nop_wfi_red", K_RED, 32'd0);
    exp_sig("nop_wfi_mode", K_MODE, 32'd3); tick(); idle();
    exp_sig("nop_wfi_stall2", K_STALL, 32'd0); tick();
    valid = 1'b1; pc = 32'h40; irq_ext = 1'b1;
    exp_sig("noirq_red", K_RED, 32'd0); exp_csr("noirq_mcause", A_MCAUSE, 32'hDEAD_BEEF);
    tick(); idle(); irq_ext = 1'b0;
    rst = 1'b1;
    #1;
    exp_sig("rst2_mode", K_MODE, 32'd3); exp_sig("rst2_stall", K_STALL, 32'd0);
    exp_csr("rst2_mstatus", A_MSTATUS, 32'h0); exp_csr("rst2_mtvec", A_MTVEC, 32'h100);
    drain();
    @(negedge clk) rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
